id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of cycles from halt-ECALL entering EX to is_halted assertion.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1: asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have port id_valid, input, 1: the ID stage holds a real instruction.
REQ-005 SHALL have ports id_pc, id_rs1_data, id_rs2_data and id_imm, each input, 32, carrying the ID-stage PC, operands and immediate.
REQ-006 SHALL have ports id_rs1, id_rs2 and id_rd, each input, 5, carrying the register indices.
REQ-007 SHALL have ports id_funct3 (input, 3) and id_funct7_5 (input, 1, instr[30]).
REQ-008 SHALL have port id_ctrl, input, 8, packed as {is_ecall, alu_op[1:0], write_enable, alu_src, mem_write, mem_to_reg, mem_read} from the decode control unit.
REQ-009 SHALL have port stall_in, input, 1: external hold request.
REQ-010 SHALL have port flush, input, 1: kill the instruction entering EX.
REQ-011 SHALL have outputs ex_valid (1), ex_pc, ex_rs1_data, ex_rs2_data and ex_imm (32 each), ex_rs1, ex_rs2 and ex_rd (5 each), ex_funct3 (3), ex_funct7_5 (1) and ex_ctrl (8), all registered copies of the id_* inputs.
REQ-012 SHALL have output hazard_stall, 1, combinational load-use stall to the PC and IF/ID logic.
REQ-013 SHALL have output is_halted, 1, registered and sticky, indicating program termination.

Function
REQ-014 SHALL update all ex_* registers only on a rising clk edge, with one cycle of latency from id_* to ex_*.
REQ-015 SHALL define a bubble as ex_valid=0, ex_ctrl=0, ex_rd=0, and all other ex_* fields = 0.
REQ-016 SHALL apply this per-edge priority while in RUN: flush loads a bubble; otherwise stall_in holds all ex_* registers; otherwise hazard_stall loads a bubble; otherwise id_* is loaded, with ex_valid=id_valid.
REQ-017 SHALL load a bubble, not the id_* fields, whenever id_valid=0 is loaded.
REQ-018 SHALL drive hazard_stall=1 iff state=RUN, ex_valid=1, ex_ctrl.mem_read=1, ex_rd!=0, id_valid=1, and (ex_rd==id_rs1 or ex_rd==id_rs2).
REQ-019 SHALL implement a state machine with states RUN, DRAIN and HALTED.
REQ-020 SHALL treat an accepted load (REQ-016 last case) with id_ctrl.is_ecall=1 and id_rs1_data==32'd10 as a halt-ECALL: on the same edge it SHALL move RUN->DRAIN and load the drain counter with DRAIN_CYCLES-1.
REQ-021 SHALL pass an ECALL whose id_rs1_data!=10 through as an ordinary instruction, with no state change.
REQ-022 SHALL decrement the drain counter by 1 per edge in DRAIN, and at count 0 SHALL move to HALTED on that edge.
REQ-023 SHALL load a bubble on every edge in DRAIN and HALTED, ignoring id_*, stall_in and flush.
REQ-024 SHALL drive is_halted=1 exactly when state=HALTED, and SHALL hold it until reset.
REQ-025 SHALL not enter DRAIN from a halt-ECALL that is flushed, held by stall_in, or converted to a bubble by hazard_stall.
REQ-026 SHALL size the drain counter at $clog2(DRAIN_CYCLES+1) bits; DRAIN_CYCLES=1 gives RUN->DRAIN->HALTED across two edges.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state=RUN, the drain counter to 0, all ex_* registers to the bubble values and is_halted=0, independent of clk.
REQ-028 SHALL resume in RUN and accept id_* on the first rising edge after reset deasserts.
REQ-029 SHALL return to RUN with a bubble in EX if reset asserts in DRAIN or HALTED.

Verification
REQ-030 SHALL cover pass-through: id_valid=1, id_pc=0x100, id_rd=5, id_ctrl=0x0C, no stall or flush -> next cycle ex_valid=1, ex_pc=0x100, ex_rd=5, ex_ctrl=0x0C.
REQ-031 SHALL cover load-use: EX holds a valid load with ex_rd=7 and ID has id_rs2=7 -> hazard_stall=1 that cycle; the next EX is a bubble and hazard_stall then drops.
REQ-032 SHALL cover priority: flush=1 and stall_in=1 together -> bubble loaded; stall_in=1 alone for 3 cycles -> ex_* unchanged across all 3.
REQ-033 SHALL cover halt: ECALL with id_rs1_data=10 and DRAIN_CYCLES=3 -> is_halted=1 exactly 3 edges after the ECALL enters EX; id_valid=1 inputs meanwhile yield only bubbles.
REQ-034 SHALL cover the non-halt ECALL: id_rs1_data=9 -> ex_ctrl[7]=1 and ex_valid=1, and is_halted stays 0.
REQ-035 SHALL cover reset mid-drain: reset=0 pulsed between clk edges in DRAIN -> ex_valid=0 and is_halted=0 immediately, and normal loading resumes after release.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core, with load-use hazard
// detection and a halt-ECALL drain sequence that ends in a sticky halt.
module id_ex_stage #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [2:0]  id_funct3,
    input  logic        id_funct7_5,
    input  logic [7:0]  id_ctrl,
    input  logic        stall_in,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7_5,
    output logic [7:0]  ex_ctrl,
    output logic        hazard_stall,
    output logic        is_halted
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic [7:0]  ctrl;
    } ex_t;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          halted_q;
    ex_t           ex_q;
    ex_t           ex_d;
    ex_t           id_bundle;

    logic run;
    logic ex_is_load;
    logic rd_match;
    logic hold;
    logic load_id;
    logic halt_ecall;

    assign id_bundle = '{
        valid:    id_valid,
        pc:       id_pc,
        rs1_data: id_rs1_data,
        rs2_data: id_rs2_data,
        imm:      id_imm,
        rs1:      id_rs1,
        rs2:      id_rs2,
        rd:       id_rd,
        funct3:   id_funct3,
        funct7_5: id_funct7_5,
        ctrl:     id_ctrl
    };

    assign run        = (state_q == RUN);
    assign ex_is_load = ex_q.valid && ex_q.ctrl[0]
                        && (ex_q.rd != 5'd0);
    assign rd_match   = (ex_q.rd == id_rs1)
                        || (ex_q.rd == id_rs2);

    assign hazard_stall = run && ex_is_load
                          && id_valid && rd_match;

    // Priority: flush > stall_in > load-use bubble > load.
    assign hold    = run && !flush && stall_in;
    assign load_id = run && !flush && !stall_in
                     && !hazard_stall && id_valid;

    assign halt_ecall = load_id && id_ctrl[7]
                        && (id_rs1_data == 32'd10);

    always_comb begin
        ex_d = '0;
        unique case (1'b1)
            hold:    ex_d = ex_q;
            load_id: ex_d = id_bundle;
            default: ex_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Halt FSM; the counter holds the edges left in DRAIN minus one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (halt_ecall) begin
                        state_q <= DRAIN;
                        cnt_q   <= CNT_INIT;
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= RUN;
                    cnt_q    <= '0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7_5 = ex_q.funct7_5;
    assign ex_ctrl     = ex_q.ctrl;
    assign is_halted   = halted_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model predicts
// each EX register state and hazard_stall, monitors compare them.
module tb_id_ex_stage;

    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0;
    logic [31:0] id_rs1_data = '0;
    logic [31:0] id_rs2_data = '0;
    logic [31:0] id_imm = '0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic [2:0]  id_funct3 = '0;
    logic        id_funct7_5 = 1'b0;
    logic [7:0]  id_ctrl = '0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_5;
    logic [7:0]  ex_ctrl;
    logic        hazard_stall;
    logic        is_halted;

    id_ex_stage #(.DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7_5(id_funct7_5), .id_ctrl(id_ctrl),
        .stall_in(stall_in), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7_5(ex_funct7_5), .ex_ctrl(ex_ctrl),
        .hazard_stall(hazard_stall), .is_halted(is_halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [7:0]  ctrl;
        logic        halted;
    } ex_t;

    typedef struct {
        logic        v;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [7:0]  ctrl;
        logic        st, fl;
    } in_t;

    int tests = 0;
    int fails = 0;

    ex_t  exp_q[$];
    logic hz_q[$];

    // Model: mode 0 = running, 1 = draining, 2 = halted.
    ex_t m_ex;
    int  m_mode;
    int  m_left;

    function automatic void check(string name, logic [255:0] act,
                                  logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        m_ex   = '0;
        m_mode = 0;
        m_left = 0;
    endfunction

    task automatic model_step(input in_t s);
        logic hz;
        logic hit;
        ex_t  nx;
        hit = (m_ex.rd == s.rs1) || (m_ex.rd == s.rs2);
        hz  = (m_mode == 0) && m_ex.v && m_ex.ctrl[0]
              && (m_ex.rd != 0) && s.v && hit;
        nx = '0;
        if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end else if (m_mode == 0) begin
            if (s.fl) nx = '0;
            else if (s.st) nx = m_ex;
            else if (hz || !s.v) nx = '0;
            else begin
                nx = '{v:1'b1, pc:s.pc, a:s.a, b:s.b,
                       imm:s.imm, rs1:s.rs1, rs2:s.rs2,
                       rd:s.rd, f3:s.f3, f7:s.f7,
                       ctrl:s.ctrl, halted:1'b0};
                if (s.ctrl[7] && s.a == 32'd10) begin
                    m_mode = 1;
                    m_left = DC;
                end
            end
        end
        nx.halted = (m_mode == 2);
        m_ex = nx;
        hz_q.push_back(hz);
        exp_q.push_back(m_ex);
    endtask

    task automatic drive(input in_t s);
        id_valid    = s.v;
        id_pc       = s.pc;
        id_rs1_data = s.a;
        id_rs2_data = s.b;
        id_imm      = s.imm;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_rd       = s.rd;
        id_funct3   = s.f3;
        id_funct7_5 = s.f7;
        id_ctrl     = s.ctrl;
        stall_in    = s.st;
        flush       = s.fl;
    endtask

    task automatic cycle(input in_t s, input bit rst_pulse);
        @(negedge clk);
        if (rst_pulse) begin
            reset = 1'b0;
            #1;
            check("async_reset", 256'({ex_valid, is_halted,
                  ex_ctrl, ex_rd, ex_pc}), 256'(0));
            reset = 1'b1;
            model_reset();
        end
        drive(s);
        model_step(s);
    endtask

    function automatic in_t mk(logic v, logic [31:0] pc,
                               logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, logic [7:0] ctrl,
                               logic [31:0] a);
        in_t s;
        s = '{v:v, pc:pc, a:a, b:32'h5A5A_0001,
              imm:32'h0000_0044, rs1:rs1, rs2:rs2, rd:rd,
              f3:3'd2, f7:1'b1, ctrl:ctrl, st:1'b0, fl:1'b0};
        return s;
    endfunction

    function automatic in_t rnd();
        in_t s;
        s.v    = ($urandom_range(0, 7) != 0);
        s.pc   = $urandom;
        s.a    = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
        s.b    = $urandom;
        s.imm  = $urandom;
        s.rs1  = 5'($urandom_range(0, 3));
        s.rs2  = 5'($urandom_range(0, 3));
        s.rd   = 5'($urandom_range(0, 3));
        s.f3   = 3'($urandom);
        s.f7   = 1'($urandom);
        s.ctrl = 8'($urandom);
        s.ctrl[7] = ($urandom_range(0, 9) == 0);
        s.st   = ($urandom_range(0, 7) == 0);
        s.fl   = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    // EX register monitor
    initial begin
        ex_t act;
        ex_t req;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                req = exp_q.pop_front();
                act = '{v:ex_valid, pc:ex_pc, a:ex_rs1_data,
                        b:ex_rs2_data, imm:ex_imm, rs1:ex_rs1,
                        rs2:ex_rs2, rd:ex_rd, f3:ex_funct3,
                        f7:ex_funct7_5, ctrl:ex_ctrl,
                        halted:is_halted};
                check("ex_regs", 256'(act), 256'(req));
            end
        end
    end

    // hazard_stall monitor
    initial begin
        logic req;
        forever begin
            @(negedge clk);
            #3;
            if (hz_q.size() > 0) begin
                req = hz_q.pop_front();
                check("hazard_stall", 256'(hazard_stall),
                      256'(req));
            end
        end
    end

    initial begin
        in_t s;
        model_reset();
        #3;
        check("reset_state", 256'({ex_valid, is_halted,
              hazard_stall, ex_ctrl, ex_rd, ex_pc}), 256'(0));
        @(negedge clk);
        reset = 1'b1;

        cycle(mk(1, 32'h100, 5, 1, 2, 8'h0C, 32'd3), 0);
        cycle(mk(1, 32'h104, 7, 1, 2, 8'h09, 32'd4), 0);
        cycle(mk(1, 32'h108, 3, 1, 7, 8'h0C, 32'd5), 0);
        cycle(mk(1, 32'h108, 3, 1, 7, 8'h0C, 32'd5), 0);
        s = mk(1, 32'h10C, 4, 0, 0, 8'h0C, 32'd6);
        s.st = 1'b1;
        s.fl = 1'b1;
        cycle(s, 0);
        cycle(mk(1, 32'h110, 6, 0, 0, 8'h0C, 32'd7), 0);
        for (int i = 0; i < 3; i++) begin
            s = mk(1, 32'h200 + 32'(i), 9, 0, 0, 8'h0C, 32'd8);
            s.st = 1'b1;
            cycle(s, 0);
        end
        cycle(mk(1, 32'h114, 1, 0, 0, 8'h84, 32'd9), 0);
        cycle(mk(1, 32'h118, 1, 0, 0, 8'h80, 32'd10), 0);
        for (int i = 0; i < 5; i++)
            cycle(mk(1, 32'h300 + 32'(i), 2, 0, 0, 8'h0C,
                     32'd1), 0);
        cycle(mk(1, 32'h11C, 2, 0, 0, 8'h0C, 32'd1), 1);
        cycle(mk(1, 32'h120, 1, 0, 0, 8'h80, 32'd10), 0);
        cycle(mk(1, 32'h124, 2, 0, 0, 8'h0C, 32'd1), 0);
        cycle(mk(1, 32'h128, 3, 0, 0, 8'h0C, 32'd1), 1);
        cycle(mk(1, 32'h12C, 4, 0, 0, 8'h0C, 32'd1), 0);

        for (int i = 0; i < 3000; i++) begin
            bit rp;
            rp = (m_mode == 2) ? ($urandom_range(0, 3) == 0)
                               : ($urandom_range(0, 199) == 0);
            cycle(rnd(), rp);
        end

        @(posedge clk);
        #2;
        check("queues_drained", 256'(exp_q.size() + hz_q.size()),
              256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
